// File: rtl/id_dispatch_buffer_pkg.sv
// Shared constants for the ID/EX dispatch buffer: side-dispatch channel indices
// for the multi-cycle execution units.
package id_dispatch_buffer_pkg;

   localparam int CH_MUL          = 0;
   localparam int CH_DIV          = 1;
   localparam int CH_FPU          = 2;
   localparam int NUM_DISPATCH_CH = 3;

endpackage

// File: rtl/id_dispatch_buffer.sv
// ID/EX boundary buffer: DEPTH-entry ring of decoded entries with per-head
// side-dispatch handshakes and drain-alone handling for serialising entries.
module id_dispatch_buffer
   import id_dispatch_buffer_pkg::*;
#(
   parameter int W         = 64,
   parameter int DEPTH     = 2,
   parameter int NUM_CH    = NUM_DISPATCH_CH,
   parameter int SIDE_GATE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush_in,
   output logic              flush_out,
   input  logic              valid_in,
   output logic              ready_out,
   input  logic [W-1:0]      payload_in,
   input  logic [NUM_CH-1:0] ch_sel_in,
   input  logic              serial_in,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [W-1:0]      payload_out,
   output logic [NUM_CH-1:0] valid_out_ch,
   input  logic [NUM_CH-1:0] ready_in_ch,
   output logic              busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);

   logic [W-1:0]      payload_mem [DEPTH];
   logic [NUM_CH-1:0] ch_mem      [DEPTH];

   logic [DEPTH-1:0]  serial_reg, serial_next, serial_live;
   logic [PW-1:0]     head_reg, head_next, head_inc;
   logic [PW-1:0]     tail_reg, tail_next, tail_inc;
   logic [CW-1:0]     count_reg, count_next, eff;
   logic [NUM_CH-1:0] pend_reg, pend_next;
   logic              nonempty, retire, accept, serial_present;

   assign head_inc = (head_reg == LAST_PTR) ? '0 : head_reg + PW'(1);
   assign tail_inc = (tail_reg == LAST_PTR) ? '0 : tail_reg + PW'(1);

   assign nonempty     = (count_reg != '0);
   assign valid_out    = (SIDE_GATE != 0) ? (nonempty && (pend_reg == '0)) : nonempty;
   assign valid_out_ch = pend_reg & {NUM_CH{nonempty}};
   assign payload_out  = nonempty ? payload_mem[head_reg] : '0;
   assign busy         = nonempty;
   assign flush_out    = flush_in;

   assign retire = valid_out && ready_in && !flush_in;
   assign eff    = count_reg - CW'(retire);

   // A serialising head that retires this cycle no longer blocks the next entry.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_live
         assign serial_live[gi] = serial_reg[gi] && !(retire && (head_reg == PW'(gi)));
      end
   endgenerate

   assign serial_present = |serial_live;
   assign ready_out = !flush_in && !serial_present && (eff < DEPTH_C)
                      && (!serial_in || (eff == '0));
   assign accept    = valid_in && ready_out;

   always_comb begin
      count_next  = count_reg + CW'(accept) - CW'(retire);
      head_next   = retire ? head_inc : head_reg;
      tail_next   = accept ? tail_inc : tail_reg;
      serial_next = serial_live;
      if (accept) begin
         serial_next[tail_reg] = serial_in;
      end

      // Pending side bits follow the head; a new head's ch_sel replaces any leftovers.
      pend_next = pend_reg & ~(valid_out_ch & ready_in_ch);
      if (retire) begin
         if (count_reg > CW'(1)) begin
            pend_next = ch_mem[head_inc];
         end else if (accept) begin
            pend_next = ch_sel_in;
         end else begin
            pend_next = '0;
         end
      end else if (accept && (count_reg == '0)) begin
         pend_next = ch_sel_in;
      end

      if (flush_in) begin
         count_next  = '0;
         head_next   = '0;
         tail_next   = '0;
         serial_next = '0;
         pend_next   = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg  <= '0;
         head_reg   <= '0;
         tail_reg   <= '0;
         serial_reg <= '0;
         pend_reg   <= '0;
      end else begin
         count_reg  <= count_next;
         head_reg   <= head_next;
         tail_reg   <= tail_next;
         serial_reg <= serial_next;
         pend_reg   <= pend_next;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         payload_mem[tail_reg] <= payload_in;
         ch_mem[tail_reg]      <= ch_sel_in;
      end
   end

endmodule

// File: tb/tb_id_dispatch_buffer.sv
// Bench for id_dispatch_buffer: three instances (DEPTH=2 ungated, DEPTH=2 gated,
// DEPTH=3 ungated) share one stimulus bus; each test targets one instance.
module tb_id_dispatch_buffer;
   import id_dispatch_buffer_pkg::*;

   localparam int W  = 64;
   localparam int NC = NUM_DISPATCH_CH;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          flush_in = 1'b0, valid_in = 1'b0, serial_in = 1'b0, ready_in = 1'b0;
   logic [W-1:0]  payload_in = '0;
   logic [NC-1:0] ch_sel_in = '0, ready_in_ch = '0;

   logic          a_flush_out, a_ready_out, a_valid_out, a_busy;
   logic [W-1:0]  a_payload_out;
   logic [NC-1:0] a_valid_out_ch;
   logic          g_flush_out, g_ready_out, g_valid_out, g_busy;
   logic [W-1:0]  g_payload_out;
   logic [NC-1:0] g_valid_out_ch;
   logic          w_flush_out, w_ready_out, w_valid_out, w_busy;
   logic [W-1:0]  w_payload_out;
   logic [NC-1:0] w_valid_out_ch;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_dispatch_buffer #(.W(W), .DEPTH(2), .NUM_CH(NC), .SIDE_GATE(0)) u_a (
      .clk(clk), .reset(reset), .flush_in(flush_in), .flush_out(a_flush_out),
      .valid_in(valid_in), .ready_out(a_ready_out), .payload_in(payload_in),
      .ch_sel_in(ch_sel_in), .serial_in(serial_in), .valid_out(a_valid_out),
      .ready_in(ready_in), .payload_out(a_payload_out), .valid_out_ch(a_valid_out_ch),
      .ready_in_ch(ready_in_ch), .busy(a_busy));

   id_dispatch_buffer #(.W(W), .DEPTH(2), .NUM_CH(NC), .SIDE_GATE(1)) u_g (
      .clk(clk), .reset(reset), .flush_in(flush_in), .flush_out(g_flush_out),
      .valid_in(valid_in), .ready_out(g_ready_out), .payload_in(payload_in),
      .ch_sel_in(ch_sel_in), .serial_in(serial_in), .valid_out(g_valid_out),
      .ready_in(ready_in), .payload_out(g_payload_out), .valid_out_ch(g_valid_out_ch),
      .ready_in_ch(ready_in_ch), .busy(g_busy));

   id_dispatch_buffer #(.W(W), .DEPTH(3), .NUM_CH(NC), .SIDE_GATE(0)) u_w (
      .clk(clk), .reset(reset), .flush_in(flush_in), .flush_out(w_flush_out),
      .valid_in(valid_in), .ready_out(w_ready_out), .payload_in(payload_in),
      .ch_sel_in(ch_sel_in), .serial_in(serial_in), .valid_out(w_valid_out),
      .ready_in(ready_in), .payload_out(w_payload_out), .valid_out_ch(w_valid_out_ch),
      .ready_in_ch(ready_in_ch), .busy(w_busy));

   typedef struct {
      logic        f, v;
      logic [63:0] p;
      logic [2:0]  ch;
      logic        s, r;
      logic [2:0]  rch;
      logic        e_rdy, e_vld;
      logic [63:0] e_pay;
      logic [2:0]  e_vch;
      logic        e_busy;
   } vec_t;

   localparam int NVEC = 29;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic f, input logic v, input logic [63:0] p,
                               input logic [2:0] ch, input logic s, input logic r,
                               input logic [2:0] rch, input logic e_rdy, input logic e_vld,
                               input logic [63:0] e_pay, input logic [2:0] e_vch,
                               input logic e_busy);
      vec_t t;
      t.f = f; t.v = v; t.p = p; t.ch = ch; t.s = s; t.r = r; t.rch = rch;
      t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_pay = e_pay; t.e_vch = e_vch; t.e_busy = e_busy;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change just after the falling edge; outputs are sampled 1ns later.
   task automatic drive(input logic f, input logic v, input logic [63:0] p, input logic [2:0] ch,
                        input logic s, input logic r, input logic [2:0] rch);
      @(negedge clk);
      flush_in = f; valid_in = v; payload_in = p; ch_sel_in = ch;
      serial_in = s; ready_in = r; ready_in_ch = rch;
      #1;
   endtask

   task automatic clear();
      drive(1'b1, 1'b0, 64'd0, 3'd0, 1'b0, 1'b0, 3'd0);
   endtask

   task automatic run_stream(input bit use_w, input int n, input int depth, input bit rnd,
                             input logic [63:0] base);
      logic [63:0] q[$];
      logic [63:0] exp_pay, pay;
      int   cnt = 0, pushed = 0, popped = 0, cyc = 0, first_ret = -1, last_ret = -1;
      logic rdy, vld, ret, acc, e_rdy;
      while (popped < n && cyc < 200) begin
         drive(1'b0, 1'(pushed < n), base + 64'(pushed), 3'd0, 1'b0,
               rnd ? 1'($urandom_range(0, 1)) : 1'b1, 3'd0);
         rdy = use_w ? w_ready_out   : a_ready_out;
         vld = use_w ? w_valid_out   : a_valid_out;
         pay = use_w ? w_payload_out : a_payload_out;
         ret   = (cnt != 0) && ready_in;
         e_rdy = ((cnt - int'(ret)) < depth);
         acc   = valid_in && e_rdy;
         check("stream_ready_out", 64'(rdy), 64'(e_rdy));
         check("stream_valid_out", 64'(vld), 64'(cnt != 0));
         if (ret) begin
            exp_pay = q.pop_front();
            check("stream_payload", pay, exp_pay);
            $display("stream depth=%0d cyc=%0d retire payload=%h expected=%h",
                     depth, cyc, pay, exp_pay);
            if (first_ret < 0) first_ret = cyc;
            last_ret = cyc;
            popped++;
         end
         if (acc) begin
            q.push_back(base + 64'(pushed));
            pushed++;
         end
         cnt = cnt + int'(acc) - int'(ret);
         cyc++;
      end
      check("stream_done", 64'(popped), 64'(n));
      if (!rnd) begin
         check("stream_latency", 64'(first_ret), 64'd1);
         check("stream_no_bubble", 64'(last_ret - first_ret), 64'(n - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vecs[0]  = mk(0, 1, 'hA,  3'b000, 0, 0, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[1]  = mk(0, 1, 'hB,  3'b000, 0, 0, 3'b000, 1, 1, 'hA,   3'b000, 1);
      vecs[2]  = mk(0, 1, 'hC,  3'b000, 0, 0, 3'b000, 0, 1, 'hA,   3'b000, 1);
      vecs[3]  = mk(0, 0, 0,    3'b000, 0, 1, 3'b000, 1, 1, 'hA,   3'b000, 1);
      vecs[4]  = mk(0, 0, 0,    3'b000, 0, 1, 3'b000, 1, 1, 'hB,   3'b000, 1);
      vecs[5]  = mk(0, 0, 0,    3'b000, 0, 0, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[6]  = mk(0, 1, 'h51, 3'b000, 1, 0, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[7]  = mk(0, 1, 'h52, 3'b000, 0, 0, 3'b000, 0, 1, 'h51,  3'b000, 1);
      vecs[8]  = mk(0, 1, 'h52, 3'b000, 0, 0, 3'b000, 0, 1, 'h51,  3'b000, 1);
      vecs[9]  = mk(0, 1, 'h52, 3'b000, 0, 1, 3'b000, 1, 1, 'h51,  3'b000, 1);
      vecs[10] = mk(0, 0, 0,    3'b000, 0, 1, 3'b000, 1, 1, 'h52,  3'b000, 1);
      vecs[11] = mk(0, 0, 0,    3'b000, 0, 0, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[12] = mk(0, 1, 'h61, 3'b000, 0, 0, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[13] = mk(0, 1, 'h62, 3'b000, 1, 0, 3'b000, 0, 1, 'h61,  3'b000, 1);
      vecs[14] = mk(0, 1, 'h62, 3'b000, 1, 1, 3'b000, 1, 1, 'h61,  3'b000, 1);
      vecs[15] = mk(0, 1, 'h63, 3'b000, 0, 0, 3'b000, 0, 1, 'h62,  3'b000, 1);
      vecs[16] = mk(0, 0, 0,    3'b000, 0, 1, 3'b000, 1, 1, 'h62,  3'b000, 1);
      vecs[17] = mk(0, 0, 0,    3'b000, 0, 0, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[18] = mk(0, 1, 'h71, 3'b101, 0, 1, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[19] = mk(0, 0, 0,    3'b000, 0, 1, 3'b000, 1, 1, 'h71,  3'b101, 1);
      vecs[20] = mk(0, 0, 0,    3'b000, 0, 0, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[21] = mk(0, 1, 'h81, 3'b001, 0, 0, 3'b000, 1, 0, 0,     3'b000, 0);
      vecs[22] = mk(0, 1, 'h82, 3'b010, 0, 0, 3'b001, 1, 1, 'h81,  3'b001, 1);
      vecs[23] = mk(0, 0, 0,    3'b000, 0, 0, 3'b000, 0, 1, 'h81,  3'b000, 1);
      vecs[24] = mk(0, 0, 0,    3'b000, 0, 1, 3'b000, 1, 1, 'h81,  3'b000, 1);
      vecs[25] = mk(0, 0, 0,    3'b000, 0, 0, 3'b000, 1, 1, 'h82,  3'b010, 1);
      vecs[26] = mk(0, 1, 'h83, 3'b100, 0, 0, 3'b000, 1, 1, 'h82,  3'b010, 1);
      vecs[27] = mk(1, 1, 'h84, 3'b000, 0, 1, 3'b010, 0, 1, 'h82,  3'b010, 1);
      vecs[28] = mk(0, 0, 0,    3'b000, 0, 0, 3'b000, 1, 0, 0,     3'b000, 0);

      #1;
      check("reset_valid_out",    64'(a_valid_out), 64'd0);
      check("reset_valid_out_ch", 64'(a_valid_out_ch), 64'd0);
      check("reset_payload_out",  a_payload_out, 64'd0);
      check("reset_busy",         64'(a_busy), 64'd0);
      check("reset_gated_busy",   64'(g_busy), 64'd0);
      check("reset_depth3_busy",  64'(w_busy), 64'd0);
      @(negedge clk);
      reset = 1'b0;

      run_stream(1'b0, 8, 2, 1'b0, 64'd1);
      clear();

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].f, vecs[i].v, vecs[i].p, vecs[i].ch, vecs[i].s, vecs[i].r, vecs[i].rch);
         $display("vec %0d: rdy=%0b vld=%0b pay=%h vch=%b busy=%0b", i,
                  a_ready_out, a_valid_out, a_payload_out, a_valid_out_ch, a_busy);
         check($sformatf("vec%0d_ready_out", i),    64'(a_ready_out),    64'(vecs[i].e_rdy));
         check($sformatf("vec%0d_valid_out", i),    64'(a_valid_out),    64'(vecs[i].e_vld));
         check($sformatf("vec%0d_payload_out", i),  a_payload_out,       vecs[i].e_pay);
         check($sformatf("vec%0d_valid_out_ch", i), 64'(a_valid_out_ch), 64'(vecs[i].e_vch));
         check($sformatf("vec%0d_busy", i),         64'(a_busy),         64'(vecs[i].e_busy));
         check($sformatf("vec%0d_flush_out", i),    64'(a_flush_out),    64'(vecs[i].f));
      end

      // Gated instance: main valid waits for every selected side channel.
      clear();
      drive(0, 1, 'h91, 3'b101, 0, 1, 3'b000);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 3'b000, 0, 1, 3'b000);
         check("gate_hold_valid_out", 64'(g_valid_out), 64'd0);
         check("gate_hold_valid_ch",  64'(g_valid_out_ch), 64'b101);
      end
      drive(0, 0, 0, 3'b000, 0, 1, 3'b001);
      check("gate_ch0_valid_out", 64'(g_valid_out), 64'd0);
      drive(0, 0, 0, 3'b000, 0, 1, 3'b000);
      check("gate_after_ch0_vch", 64'(g_valid_out_ch), 64'b100);
      drive(0, 0, 0, 3'b000, 0, 1, 3'b100);
      check("gate_ch2_valid_out", 64'(g_valid_out), 64'd0);
      drive(0, 0, 0, 3'b000, 0, 1, 3'b000);
      check("gate_rise_valid_out", 64'(g_valid_out), 64'd1);
      check("gate_rise_payload",   g_payload_out, 64'h91);
      check("gate_rise_vch",       64'(g_valid_out_ch), 64'd0);
      drive(0, 0, 0, 3'b000, 0, 0, 3'b000);
      check("gate_retired_busy", 64'(g_busy), 64'd0);
      $display("gated dispatch: side accepts then main retire of 91");

      // Asynchronous reset between clock edges with two entries held.
      clear();
      drive(0, 1, 'hA1, 3'b010, 0, 0, 3'b000);
      drive(0, 1, 'hA2, 3'b000, 0, 0, 3'b000);
      drive(0, 0, 0, 3'b000, 0, 0, 3'b000);
      check("prereset_busy", 64'(a_busy), 64'd1);
      check("prereset_vch",  64'(a_valid_out_ch), 64'b010);
      #1 reset = 1'b1;
      #1;
      check("async_reset_valid_out", 64'(a_valid_out), 64'd0);
      check("async_reset_vch",       64'(a_valid_out_ch), 64'd0);
      check("async_reset_payload",   a_payload_out, 64'd0);
      check("async_reset_busy",      64'(a_busy), 64'd0);
      check("async_reset_gated",     64'(g_busy), 64'd0);
      $display("async reset: outputs cleared mid-cycle");
      @(negedge clk);
      reset = 1'b0;

      run_stream(1'b1, 10, 3, 1'b1, 64'h100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
